// File: rtl/elderly_mon_pkg.sv
// Shared constants and FSM state type for the
// elderly monitor sensor front-end blocks.
package elderly_mon_pkg;

  localparam int unsigned CLK_FREQ_HZ        = 50_000_000;
  localparam int unsigned DEF_WINDOW_CYCLES  = 600_000_000;
  localparam int unsigned DEF_REFRACT_CYCLES = 10_000_000;
  localparam int unsigned DEF_COUNT_W        = 8;

  typedef enum logic {
    ARMED   = 1'b0,
    REFRACT = 1'b1
  } pwc_state_e;

endpackage

// File: rtl/pulse_window_counter_if.sv
// Result bundle of the pulse window counter:
// published count, strobes and overflow flag.
interface pulse_window_counter_if
  import elderly_mon_pkg::*;
#(
  parameter int unsigned COUNT_W = DEF_COUNT_W
);

  logic [COUNT_W-1:0] pulse_count;
  logic               count_valid;
  logic               overflow;
  logic               beat;

  modport master (
    output pulse_count,
    output count_valid,
    output overflow,
    output beat
  );

  modport slave (
    input pulse_count,
    input count_valid,
    input overflow,
    input beat
  );

endinterface

// File: rtl/pulse_edge_sync.sv
// Two-flop synchroniser for an async input plus a
// registered rising-edge detector.
module pulse_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic rise_q, rise_d;

  // Shift chain and edge compare
  always_comb begin
    s1_d   = async_in;
    s2_d   = s1_q;
    s3_d   = s2_q;
    rise_d = s2_q & ~s3_q;
  end

  // Sync, history and edge registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/pulse_window_counter.sv
// Heartbeat pulse counter: refractory beat accept,
// windowed accumulation and saturated publish.
module pulse_window_counter
  import elderly_mon_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES  = DEF_WINDOW_CYCLES,
  parameter int unsigned REFRACT_CYCLES = DEF_REFRACT_CYCLES,
  parameter int unsigned COUNT_W        = DEF_COUNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic pulse_in,
  pulse_window_counter_if.master out_if
);

  localparam int unsigned WIN_W =
    (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int unsigned REF_W =
    (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST =
    WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [REF_W-1:0] REF_LOAD =
    REF_W'(REFRACT_CYCLES - 1);
  localparam logic [COUNT_W:0] SAT =
    {1'b0, {COUNT_W{1'b1}}};

  logic               rise;
  logic               accept;
  logic               sat_hit;
  logic [COUNT_W:0]   acc_tot;

  pwc_state_e         state_q, state_d;
  logic [REF_W-1:0]   ref_q, ref_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [COUNT_W:0]   acc_q, acc_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;
  logic               beat_q, beat_d;

  pulse_edge_sync u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (pulse_in),
    .rise     (rise)
  );

  // Beat acceptance, dead time and window close
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    win_d   = win_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    beat_d  = 1'b0;
    accept  = 1'b0;
    sat_hit = 1'b0;
    acc_tot = acc_q;
    if (!enable) begin
      state_d = ARMED;
      ref_d   = '0;
      win_d   = '0;
      acc_d   = '0;
    end else begin
      accept = (state_q == ARMED) && rise;
      unique case (state_q)
        ARMED: begin
          if (accept) begin
            ref_d   = REF_LOAD;
            state_d = (REF_LOAD == '0) ? ARMED : REFRACT;
          end
        end
        REFRACT: begin
          if (ref_q != '0) ref_d = ref_q - 1'b1;
          if (ref_q <= REF_W'(1)) state_d = ARMED;
        end
        default: state_d = ARMED;
      endcase
      beat_d = accept;
      // acc holds once its top bit is set so it never wraps
      if (accept && !acc_q[COUNT_W]) acc_tot = acc_q + 1'b1;
      if (win_q == WIN_LAST) begin
        sat_hit = acc_tot > SAT;
        cnt_d   = sat_hit ? '1 : acc_tot[COUNT_W-1:0];
        ovf_d   = sat_hit;
        valid_d = 1'b1;
        acc_d   = '0;
        win_d   = '0;
      end else begin
        acc_d = acc_tot;
        win_d = win_q + 1'b1;
      end
    end
  end

  // State, counters and published outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARMED;
      ref_q   <= '0;
      win_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      beat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      beat_q  <= beat_d;
    end
  end

  assign out_if.pulse_count = cnt_q;
  assign out_if.count_valid = valid_q;
  assign out_if.overflow    = ovf_q;
  assign out_if.beat        = beat_q;

endmodule

// File: tb/tb_pulse_window_counter.sv
// Bench for pulse_window_counter: 8-bit and 4-bit
// instances on shared stimulus vs a beat/window model.
module tb_pulse_window_counter;

  localparam int W = 1000;
  localparam int R = 20;

  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  logic pulse_in;

  always #5 clk = ~clk;

  pulse_window_counter_if #(.COUNT_W(8)) bus8 ();
  pulse_window_counter_if #(.COUNT_W(4)) bus4 ();

  pulse_window_counter #(
    .WINDOW_CYCLES (W),
    .REFRACT_CYCLES(R),
    .COUNT_W       (8)
  ) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .pulse_in(pulse_in),
    .out_if  (bus8)
  );

  pulse_window_counter #(
    .WINDOW_CYCLES (W),
    .REFRACT_CYCLES(R),
    .COUNT_W       (4)
  ) dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .pulse_in(pulse_in),
    .out_if  (bus4)
  );

  // pin samples of the last four edges, [1] newest
  bit h [1:4];
  int total;
  int wcnt;
  int last_acc;
  int edge_n;
  int exp_cnt8, exp_cnt4;
  bit exp_ov8, exp_ov4;
  bit exp_valid, exp_beat;

  int n_checks;
  int n_fail;
  int valid_seen;
  int beat_seen;
  int cyc;

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 1; i <= 4; i++) h[i] = 1'b0;
    total     = 0;
    wcnt      = 0;
    last_acc  = -1000000;
    exp_cnt8  = 0;
    exp_cnt4  = 0;
    exp_ov8   = 1'b0;
    exp_ov4   = 1'b0;
    exp_valid = 1'b0;
    exp_beat  = 1'b0;
  endfunction

  // One clock edge: pin seen 3 edges ago high and
  // 4 edges ago low is a rise acted on now.
  function automatic void model_edge(bit pin, bit en);
    bit rise;
    rise      = h[3] & ~h[4];
    exp_beat  = 1'b0;
    exp_valid = 1'b0;
    if (en) begin
      if (rise && (edge_n - last_acc >= R)) begin
        exp_beat = 1'b1;
        total++;
        last_acc = edge_n;
      end
      wcnt++;
      if (wcnt == W) begin
        exp_valid = 1'b1;
        exp_cnt8  = (total > 255) ? 255 : total;
        exp_ov8   = (total > 255);
        exp_cnt4  = (total > 15) ? 15 : total;
        exp_ov4   = (total > 15);
        total     = 0;
        wcnt      = 0;
      end
    end else begin
      total    = 0;
      wcnt     = 0;
      last_acc = -1000000;
    end
    h[4] = h[3];
    h[3] = h[2];
    h[2] = h[1];
    h[1] = pin;
    edge_n++;
  endfunction

  task automatic check_outputs();
    check("beat8",  32'(bus8.beat),        32'(exp_beat));
    check("valid8", 32'(bus8.count_valid), 32'(exp_valid));
    check("count8", 32'(bus8.pulse_count), exp_cnt8);
    check("ovf8",   32'(bus8.overflow),    32'(exp_ov8));
    check("beat4",  32'(bus4.beat),        32'(exp_beat));
    check("valid4", 32'(bus4.count_valid), 32'(exp_valid));
    check("count4", 32'(bus4.pulse_count), exp_cnt4);
    check("ovf4",   32'(bus4.overflow),    32'(exp_ov4));
  endtask

  task automatic check_zero(string tag);
    check({tag, "_count8"}, 32'(bus8.pulse_count), 0);
    check({tag, "_valid8"}, 32'(bus8.count_valid), 0);
    check({tag, "_ovf8"},   32'(bus8.overflow),    0);
    check({tag, "_beat8"},  32'(bus8.beat),        0);
    check({tag, "_count4"}, 32'(bus4.pulse_count), 0);
    check({tag, "_ovf4"},   32'(bus4.overflow),    0);
  endtask

  task automatic step(bit pin, bit en);
    pulse_in = pin;
    enable   = en;
    @(posedge clk);
    model_edge(pin, en);
    #1;
    check_outputs();
    valid_seen += int'(bus8.count_valid);
    beat_seen  += int'(bus8.beat);
  endtask

  task automatic drive(bit pin, bit en, int n);
    repeat (n) step(pin, en);
  endtask

  task automatic pulses(int k, int hi, int period);
    repeat (k) begin
      drive(1'b1, 1'b1, hi);
      drive(1'b0, 1'b1, period - hi);
    end
  endtask

  task automatic wait_valid(int maxc, output int n);
    n = 0;
    do begin
      step(1'b0, 1'b1);
      n++;
    end while (!bus8.count_valid && n < maxc);
    check("valid_reached", 32'(bus8.count_valid), 1);
  endtask

  task automatic reset_mid();
    #3;
    reset_n = 1'b0;
    #1;
    model_clear();
    check_zero("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    edge_n     = 0;
    valid_seen = 0;
    beat_seen  = 0;
    model_clear();
    reset_n  = 1'b0;
    enable   = 1'b0;
    pulse_in = 1'b0;
    #12;
    check_zero("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // clean pulses
    pulses(15, 10, 50);
    wait_valid(400, cyc);
    check("clean_len", 750 + cyc, W);
    check("clean_cnt", 32'(bus8.pulse_count), 15);
    check("clean_ovf", 32'(bus8.overflow), 0);
    check("clean_beats", beat_seen, 15);
    check("clean_valids", valid_seen, 1);

    // glitch rejection and refractory edge
    beat_seen = 0;
    repeat (8) begin
      drive(1'b1, 1'b1, 3);
      drive(1'b0, 1'b1, 2);
      drive(1'b1, 1'b1, 3);
      drive(1'b0, 1'b1, 52);
    end
    drive(1'b1, 1'b1, 5);
    drive(1'b0, 1'b1, 14);
    drive(1'b1, 1'b1, 5);
    drive(1'b0, 1'b1, 36);
    drive(1'b1, 1'b1, 5);
    drive(1'b0, 1'b1, 15);
    drive(1'b1, 1'b1, 5);
    drive(1'b0, 1'b1, 35);
    wait_valid(500, cyc);
    check("glitch_len", 600 + cyc, W);
    check("glitch_cnt", 32'(bus8.pulse_count), 11);
    check("glitch_beats", beat_seen, 11);

    // saturation of the narrow instance
    pulses(20, 10, 40);
    wait_valid(300, cyc);
    check("sat_cnt8", 32'(bus8.pulse_count), 20);
    check("sat_ovf8", 32'(bus8.overflow), 0);
    check("sat_cnt4", 32'(bus4.pulse_count), 15);
    check("sat_ovf4", 32'(bus4.overflow), 1);
    pulses(3, 10, 40);
    wait_valid(1000, cyc);
    check("post_cnt4", 32'(bus4.pulse_count), 3);
    check("post_ovf4", 32'(bus4.overflow), 0);

    // beat on the closing cycle
    drive(1'b1, 1'b1, 10);
    drive(1'b0, 1'b1, 90);
    drive(1'b1, 1'b1, 10);
    drive(1'b0, 1'b1, 886);
    drive(1'b1, 1'b1, 4);
    check("close_valid", 32'(bus8.count_valid), 1);
    check("close_cnt", 32'(bus8.pulse_count), 3);
    // beat on the first cycle of the next window
    drive(1'b0, 1'b1, 100);
    drive(1'b1, 1'b1, 10);
    drive(1'b0, 1'b1, 887);
    drive(1'b1, 1'b1, 3);
    check("open_prev_valid", 32'(bus8.count_valid), 1);
    check("open_prev_cnt", 32'(bus8.pulse_count), 1);
    beat_seen = 0;
    step(1'b0, 1'b1);
    check("open_first_beat", 32'(bus8.beat), 1);
    wait_valid(1100, cyc);
    check("open_len", 1 + cyc, W);
    check("open_cnt", 32'(bus8.pulse_count), 1);

    // enable low mid-window
    pulses(6, 10, 40);
    valid_seen = 0;
    drive(1'b0, 1'b0, 300);
    check("dis_valids", valid_seen, 0);
    check("dis_hold", 32'(bus8.pulse_count), 1);
    beat_seen = 0;
    pulses(4, 10, 40);
    wait_valid(1000, cyc);
    check("reen_len", 160 + cyc, W);
    check("reen_cnt", 32'(bus8.pulse_count), 4);
    check("reen_beats", beat_seen, 4);

    // async reset inside the dead time
    drive(1'b0, 1'b1, 30);
    drive(1'b1, 1'b1, 5);
    drive(1'b0, 1'b1, 3);
    reset_mid();
    beat_seen = 0;
    drive(1'b1, 1'b1, 5);
    check("rst_first_beat", beat_seen, 1);
    wait_valid(1100, cyc);
    check("rst_len", 5 + cyc, W);
    check("rst_cnt", 32'(bus8.pulse_count), 1);

    // random pulse trains and enable drops
    for (int k = 0; k < 4000; ) begin
      int hi, lo;
      if ($urandom_range(0, 9) == 0) begin
        hi = int'($urandom_range(1, 30));
        drive(bit'($urandom_range(0, 1)), 1'b0, hi);
        k += hi;
      end else begin
        hi = int'($urandom_range(1, 8));
        lo = int'($urandom_range(1, 25));
        drive(1'b1, 1'b1, hi);
        drive(1'b0, 1'b1, lo);
        k += hi + lo;
      end
    end
    drive(1'b0, 1'b1, 1100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
